vca_mixer: RTL and testbench

- Parametrised successor to the single-voice envelope amplitude scaler in the SID voice path.
- Scales NUM_VOICES unsigned waveforms by their envelopes, one voice per cycle through a single shared multiplier, and sums the enabled voices.
- Applies a master volume and saturates the result to the output width.
- Sits between the per-voice envelope/waveform generators and the audio output/DAC stage; runs once per sample strobe.

---
 rtl/vca_mixer.sv | 128 ++++++++++++
 tb/tb_vca_mixer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vca_mixer.sv
// Multi-voice envelope scaler and mixer: one voice per cycle through a shared
// multiplier, summed, scaled by master volume and saturated to OUT_W bits.
module vca_mixer #(
    parameter int NUM_VOICES = 3,
    parameter int WAVE_W     = 12,
    parameter int ENV_W      = 8,
    parameter int VOL_W      = 4,
    parameter int OUT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_stb,
    input  logic [NUM_VOICES*WAVE_W-1:0] wave_in,
    input  logic [NUM_VOICES*ENV_W-1:0]  env_in,
    input  logic [NUM_VOICES-1:0]        voice_en,
    input  logic [VOL_W-1:0]             master_vol,
    output logic [OUT_W-1:0]             mix_out,
    output logic                         mix_valid,
    output logic                         busy,
    output logic                         overrun
);
    // state | meaning
    // IDLE  | waiting for sample_stb; inputs snapshotted on the strobe
    // SCALE | one voice per cycle: wave*env >> ENV_W added to acc if enabled
    // VOL   | acc * master_vol, saturate, publish mix_out with mix_valid

    localparam int ACC_W  = WAVE_W + $clog2(NUM_VOICES + 1);
    localparam int PROD_W = WAVE_W + ENV_W;
    localparam int P_W    = ACC_W + VOL_W;
    localparam int CMP_W  = ((P_W > OUT_W) ? P_W : OUT_W) + 1;
    localparam int CH_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_VOICES - 1);
    localparam logic [CMP_W-1:0] MAX_OUT = {{(CMP_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, SCALE, VOL} state_t;

    state_t                         state;
    logic [NUM_VOICES*WAVE_W-1:0]   wave_r;
    logic [NUM_VOICES*ENV_W-1:0]    env_r;
    logic [NUM_VOICES-1:0]          en_r;
    logic [VOL_W-1:0]               vol_r;
    logic [ACC_W-1:0]               acc;
    logic [CH_W-1:0]                ch;

    logic [WAVE_W-1:0]              wave_sel;
    logic [ENV_W-1:0]               env_sel;
    logic                           en_sel;
    logic [PROD_W-1:0]              prod;
    logic [WAVE_W-1:0]              scaled;
    logic [P_W-1:0]                 p;
    logic [CMP_W-1:0]               p_ext;
    logic                           sat;

    // Compare-based mux keeps the select legal for non-power-of-two voice counts.
    always_comb begin
        wave_sel = '0;
        env_sel  = '0;
        en_sel   = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (ch == CH_W'(i)) begin
                wave_sel = wave_r[i*WAVE_W +: WAVE_W];
                env_sel  = env_r[i*ENV_W +: ENV_W];
                en_sel   = en_r[i];
            end
        end
    end

    assign prod   = PROD_W'(wave_sel) * PROD_W'(env_sel);
    assign scaled = prod[ENV_W +: WAVE_W];
    assign p      = P_W'(acc) * P_W'(vol_r);
    assign p_ext  = CMP_W'(p);
    assign sat    = (p_ext > MAX_OUT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wave_r    <= '0;
            env_r     <= '0;
            en_r      <= '0;
            vol_r     <= '0;
            acc       <= '0;
            ch        <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            if (sample_stb && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_stb) begin
                        wave_r <= wave_in;
                        env_r  <= env_in;
                        en_r   <= voice_en;
                        vol_r  <= master_vol;
                        acc    <= '0;
                        ch     <= '0;
                        busy   <= 1'b1;
                        state  <= SCALE;
                    end
                end
                SCALE: begin
                    if (en_sel) begin
                        acc <= acc + ACC_W'(scaled);
                    end
                    if (ch == LAST_CH) begin
                        state <= VOL;
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
                VOL: begin
                    mix_out   <= sat ? {OUT_W{1'b1}} : p_ext[OUT_W-1:0];
                    mix_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vca_mixer.sv
// Self-checking bench for vca_mixer: directed vector table, corner-case
// sequences, and random passes against an arithmetic reference model.
module tb_vca_mixer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_stb;
    logic [35:0] wave_in;
    logic [23:0] env_in;
    logic [2:0]  voice_en;
    logic [3:0]  master_vol;
    logic [15:0] mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;

    int tests = 0;
    int fails = 0;

    vca_mixer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_stb (sample_stb),
        .wave_in    (wave_in),
        .env_in     (env_in),
        .voice_en   (voice_en),
        .master_vol (master_vol),
        .mix_out    (mix_out),
        .mix_valid  (mix_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [35:0] w;
        logic [23:0] e;
        logic [2:0]  en;
        logic [3:0]  vol;
        longint      exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sum of enabled voices' (wave*env)/256, times volume, clamped to 16 bits.
    function automatic longint model(input logic [35:0] w, input logic [23:0] e,
                                     input logic [2:0] en, input logic [3:0] vol);
        longint sum = 0;
        longint p;
        for (int i = 0; i < 3; i++) begin
            if (en[i]) sum += (longint'(w[i*12 +: 12]) * longint'(e[i*8 +: 8])) / 256;
        end
        p = sum * longint'(vol);
        return (p > 65535) ? 65535 : p;
    endfunction

    task automatic start(input logic [35:0] w, input logic [23:0] e,
                         input logic [2:0] en, input logic [3:0] vol);
        @(negedge clk);
        wave_in    = w;
        env_in     = e;
        voice_en   = en;
        master_vol = vol;
        sample_stb = 1'b1;
        @(posedge clk);
        #1;
        sample_stb = 1'b0;
    endtask

    // Called just after the strobe edge; counts edges until mix_valid.
    task automatic wait_valid(output int lat, output int bcnt, output logic [15:0] out);
        lat  = -1;
        out  = '0;
        bcnt = busy ? 1 : 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (mix_valid) begin
                lat = k;
                out = mix_out;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic run_pass(input string name, input logic [35:0] w, input logic [23:0] e,
                            input logic [2:0] en, input logic [3:0] vol, input longint exp);
        int lat, bcnt;
        logic [15:0] out;
        start(w, e, en, vol);
        wait_valid(lat, bcnt, out);
        chk({name, "_latency"}, lat, 4);
        if (lat < 0) return;
        chk({name, "_busy_cycles"}, bcnt, 4);
        chk({name, "_mix_out"}, out, exp);
        chk({name, "_busy_done"}, busy, 0);
        @(posedge clk);
        #1;
        chk({name, "_valid_pulse"}, mix_valid, 0);
        chk({name, "_hold"}, mix_out, exp);
    endtask

    function automatic logic [35:0] w3(input int a, input int b, input int c);
        return {12'(c), 12'(b), 12'(a)};
    endfunction

    function automatic logic [23:0] e3(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    initial begin
        int lat, bcnt, nvalid;
        logic [15:0] out;
        logic [35:0] rw;
        logic [23:0] re;
        logic [2:0]  ren;
        logic [3:0]  rvol;

        vecs.push_back('{"v0_half",  w3(2048, 4095, 4095), e3(128, 255, 255), 3'b001, 4'd15, 15360});
        vecs.push_back('{"full_v4",  w3(4095, 4095, 4095), e3(255, 255, 255), 3'b111, 4'd4,  48948});
        vecs.push_back('{"full_sat", w3(4095, 4095, 4095), e3(255, 255, 255), 3'b111, 4'd15, 65535});
        vecs.push_back('{"v1_only",  w3(4095, 4095, 4095), e3(255, 255, 255), 3'b010, 4'd1,  4079});
        vecs.push_back('{"none_en",  w3(4095, 4095, 4095), e3(255, 255, 255), 3'b000, 4'd15, 0});
        vecs.push_back('{"vol_zero", w3(4095, 4095, 4095), e3(255, 255, 255), 3'b111, 4'd0,  0});
        vecs.push_back('{"env_one",  w3(4095, 4095, 4095), e3(1, 1, 1),       3'b111, 4'd1,  45});
        vecs.push_back('{"trunc",    w3(1, 255, 256),      e3(255, 1, 1),     3'b111, 4'd15, 15});

        rst_n = 1'b0; sample_stb = 1'b0;
        wave_in = '0; env_in = '0; voice_en = '0; master_vol = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mix_out", mix_out, 0);
        chk("rst_mix_valid", mix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_pass(vecs[i].name, vecs[i].w, vecs[i].e, vecs[i].en, vecs[i].vol, vecs[i].exp);

        // Snapshot: inputs changed during the pass must not matter.
        start(w3(1000, 2000, 3000), e3(100, 200, 50), 3'b111, 4'd3);
        wave_in = w3(4095, 4095, 4095); env_in = e3(255, 255, 255);
        voice_en = 3'b000; master_vol = 4'd15;
        wait_valid(lat, bcnt, out);
        chk("snap_latency", lat, 4);
        chk("snap_mix_out", out, model(w3(1000, 2000, 3000), e3(100, 200, 50), 3'b111, 4'd3));

        // Overrun: second strobe two cycles after the first.
        chk("pre_overrun", overrun, 0);
        start(w3(2048, 0, 0), e3(128, 0, 0), 3'b001, 4'd2);
        nvalid = 0;
        @(posedge clk); #1;
        if (mix_valid) nvalid++;
        @(negedge clk);
        sample_stb = 1'b1;
        @(posedge clk); #1;
        sample_stb = 1'b0;
        if (mix_valid) nvalid++;
        chk("overrun_set", overrun, 1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (mix_valid) begin
                nvalid++;
                chk("overrun_mix_out", mix_out, 2048);
            end
        end
        chk("overrun_one_valid", nvalid, 1);
        chk("overrun_sticky", overrun, 1);
        run_pass("after_overrun", w3(100, 200, 300), e3(255, 255, 255), 3'b111, 4'd1,
                 model(w3(100, 200, 300), e3(255, 255, 255), 3'b111, 4'd1));
        chk("overrun_still", overrun, 1);

        // Reset during SCALE aborts the pass.
        start(w3(4095, 4095, 4095), e3(255, 255, 255), 3'b111, 4'd1);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_mix_out", mix_out, 0);
        chk("midrst_valid", mix_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (mix_valid) nvalid++;
        end
        chk("midrst_no_valid", nvalid, 0);
        run_pass("after_rst", w3(2048, 0, 0), e3(128, 0, 0), 3'b001, 4'd15, 15360);

        for (int n = 0; n < 24; n++) begin
            rw   = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))};
            re   = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
            ren  = 3'($urandom_range(0, 7));
            rvol = 4'($urandom_range(0, 15));
            run_pass("rand", rw, re, ren, rvol, model(rw, re, ren, rvol));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
